// File: rtl/mult_fu_pkg.sv
// mult_fu_pkg: shared types and branch-mask helpers for the pipelined multiply unit
package mult_fu_pkg;
  localparam int BR_W = 4;
  localparam int TAG_W = 6;
  typedef logic [BR_W-1:0] BR_MASK;
  typedef enum logic [1:0] {NOTHING, CLEAR, SQUASH} BR_TASK;
  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} MULT_FUNC;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] dest_tag;
    BR_MASK b_mask;
    BR_MASK b_id;
  } DECODED_PACKET;
  typedef struct packed {
    DECODED_PACKET decoded_vals;
    MULT_FUNC func;
  } RS_PACKET;
  typedef struct packed {
    DECODED_PACKET decoded_vals;
    logic [31:0] result;
  } FU_PACKET;
  typedef struct packed {
    DECODED_PACKET decoded_vals;
    MULT_FUNC func;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] product;
  } MULT_STAGE_PKT;
  function automatic DECODED_PACKET br_update(DECODED_PACKET d, BR_TASK t, BR_MASK id);
    br_update = d;
    if (t == SQUASH && |(d.b_mask & id) && d.b_id != id) br_update.valid = 1'b0;
    if (t == CLEAR) br_update.b_mask = d.b_mask & ~id;
  endfunction
  function automatic logic [63:0] extend(logic [31:0] v, logic s);
    return {{32{s & v[31]}}, v};
  endfunction
endpackage

// File: rtl/mult_fu_if.sv
// mult_fu_if: issue, CDB and branch-resolution signals of the multiply unit
interface mult_fu_if #(parameter int XLEN = 32) ();
  import mult_fu_pkg::*;
  logic issue_valid;
  RS_PACKET issue_pkt;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic stall;
  BR_TASK rem_br_task;
  BR_MASK rem_b_id;
  logic ready;
  logic fu_done;
  FU_PACKET fu_pkt;
  modport master (output issue_valid, issue_pkt, rs1_value, rs2_value, stall, rem_br_task, rem_b_id,
                  input ready, fu_done, fu_pkt);
  modport slave (input issue_valid, issue_pkt, rs1_value, rs2_value, stall, rem_br_task, rem_b_id,
                 output ready, fu_done, fu_pkt);
endinterface

// File: rtl/mult_fu_stage.sv
// mult_stage: one W-bit partial-product step plus branch-mask update, registered
module mult_stage import mult_fu_pkg::*; #(parameter int W = 16) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  BR_TASK rem_br_task,
  input  BR_MASK rem_b_id,
  input  MULT_STAGE_PKT in_pkt,
  output MULT_STAGE_PKT out_pkt
);
  MULT_STAGE_PKT step;
  // accumulate this stage's slice of the multiplier and retire it
  always_comb begin
    step = in_pkt;
    step.product = in_pkt.product + in_pkt.mcand * 64'(in_pkt.mplier[W-1:0]);
    step.mcand = in_pkt.mcand << W;
    step.mplier = in_pkt.mplier >> W;
    step.decoded_vals = br_update(in_pkt.decoded_vals, rem_br_task, rem_b_id);
  end
  // advance when unfrozen; a frozen entry still sees squash/clear
  always_ff @(posedge clock)
    if (reset) out_pkt <= '0;
    else if (en) out_pkt <= step;
    else out_pkt.decoded_vals <= br_update(out_pkt.decoded_vals, rem_br_task, rem_b_id);
endmodule

// File: rtl/mult_fu.sv
// mult_fu: pipelined integer multiply unit; MULT_FU_STATS_EN adds completion/stall counters
module mult_fu import mult_fu_pkg::*; #(
  parameter int NUM_STAGES = 4,
  parameter int XLEN = 32
) (
  input  logic clock,
  input  logic reset,
  mult_fu_if.slave bus
`ifdef MULT_FU_STATS_EN
  ,
  output logic [31:0] stat_done_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);
  localparam int W = 64 / NUM_STAGES;
  MULT_STAGE_PKT entry;
  MULT_STAGE_PKT pipe [NUM_STAGES+1];
  MULT_STAGE_PKT last;
  logic frozen;
  logic unused_bits;
  // form the stage-0 entry with operands extended per function; no issue means a zero bubble
  always_comb begin
    entry = '0;
    if (bus.issue_valid) begin
      entry.decoded_vals = bus.issue_pkt.decoded_vals;
      entry.decoded_vals.valid = 1'b1;
      entry.func = bus.issue_pkt.func;
      entry.mcand = extend(bus.rs1_value, bus.issue_pkt.func != MULHU);
      entry.mplier = extend(bus.rs2_value, bus.issue_pkt.func == MUL || bus.issue_pkt.func == MULH);
    end
  end
  assign pipe[0] = entry;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mult_stage #(.W(W)) u_stage (
      .clock(clock),
      .reset(reset),
      .en(~frozen),
      .rem_br_task(bus.rem_br_task),
      .rem_b_id(bus.rem_b_id),
      .in_pkt(pipe[g]),
      .out_pkt(pipe[g+1])
    );
  end
  assign last = pipe[NUM_STAGES];
  assign frozen = bus.fu_done & bus.stall;
  assign bus.ready = ~frozen;
  assign bus.fu_done = last.decoded_vals.valid;
  assign bus.fu_pkt = '{decoded_vals: last.decoded_vals,
                        result: last.func == MUL ? last.product[31:0] : last.product[63:32]};
  assign unused_bits = ^{last.mcand, last.mplier};
  assert property (@(posedge clock) disable iff (reset) !(bus.issue_valid && !bus.ready));
`ifdef MULT_FU_STATS_EN
  // saturating counts of granted completions and frozen cycles
  always_ff @(posedge clock)
    if (reset) begin
      stat_done_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (bus.fu_done && !bus.stall && ~&stat_done_cnt) stat_done_cnt <= stat_done_cnt + 32'd1;
      if (frozen && ~&stat_stall_cnt) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu: vector table, corner sequences and randomized scoreboard for mult_fu
module tb_mult_fu;
  import mult_fu_pkg::*;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  mult_fu_if #(.XLEN(32)) bus ();
`ifdef MULT_FU_STATS_EN
  logic [31:0] stat_done_cnt, stat_stall_cnt;
`endif
  mult_fu #(.NUM_STAGES(N), .XLEN(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef MULT_FU_STATS_EN
    ,
    .stat_done_cnt(stat_done_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );
  always #5 clock = ~clock;

  typedef struct {
    MULT_FUNC f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;
  typedef struct {
    logic [5:0] tag;
    logic [31:0] r;
  } exp_t;
  vec_t vecs [8];
  exp_t q [$];

  function automatic logic [31:0] model(MULT_FUNC f, logic [31:0] a, logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      MULH: p = sa * sb;
      MULHSU: p = sa * ub;
      default: p = ua * ub;
    endcase
    return f == MUL ? p[31:0] : p[63:32];
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input logic v, input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input BR_MASK m);
    bus.issue_valid = v;
    bus.issue_pkt.func = f;
    bus.issue_pkt.decoded_vals = '{valid: v, dest_tag: tag, b_mask: m, b_id: 4'b0001};
    bus.rs1_value = a;
    bus.rs2_value = b;
  endtask

  task automatic idle;
    drive(1'b0, MUL, '0, '0, '0, '0);
  endtask

  task automatic grant_check(input string n);
    exp_t e;
    if (bus.fu_done && !bus.stall) begin
      if (q.size() == 0) check({n, "_spurious"}, bus.fu_done, 0);
      else begin
        e = q.pop_front();
        check({n, "_tag"}, bus.fu_pkt.decoded_vals.dest_tag, e.tag);
        check({n, "_res"}, bus.fu_pkt.result, e.r);
      end
    end
  endtask

  initial begin
    MULT_FUNC rf;
    logic [31:0] ra, rb;
    logic [5:0] rt;
    vecs[0] = '{MUL, 32'd7, 32'd6, 32'd42};
    vecs[1] = '{MULH, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2] = '{MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3] = '{MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF};
    vecs[4] = '{MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1};
    vecs[5] = '{MULH, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF};
    vecs[6] = '{MULHU, 32'h80000000, 32'd2, 32'h00000001};
    vecs[7] = '{MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    bus.stall = 1'b0;
    bus.rem_br_task = NOTHING;
    bus.rem_b_id = '0;
    idle();
    repeat (2) tick();
    reset = 1'b0;
    check("rst_done", bus.fu_done, 0);
    check("rst_ready", bus.ready, 1);
    check("rst_pkt", bus.fu_pkt, 0);

    drive(1'b1, MUL, 32'd7, 32'd6, 6'd1, '0);
    tick();
    idle();
    for (int k = 0; k < N - 1; k++) begin
      check("lat_early", bus.fu_done, 0);
      tick();
    end
    check("lat_done", bus.fu_done, 1);
    check("lat_res", bus.fu_pkt.result, 42);
    tick();
    check("lat_drop", bus.fu_done, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].f, vecs[i].a, vecs[i].b, 6'(i), '0);
      tick();
      idle();
      repeat (N - 1) tick();
      check($sformatf("vec%0d_done", i), bus.fu_done, 1);
      check($sformatf("vec%0d_res", i), bus.fu_pkt.result, vecs[i].r);
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, MUL, 32'(i + 1), 32'd10, 6'(i), '0);
      tick();
    end
    idle();
    check("stl_first", bus.fu_done, 1);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stl_ready", bus.ready, 0);
      check("stl_hold_tag", bus.fu_pkt.decoded_vals.dest_tag, 0);
      check("stl_hold_res", bus.fu_pkt.result, 10);
      tick();
    end
    bus.stall = 1'b0;
    #1;
    check("stl_release", bus.ready, 1);
    check("stl_held_tag", bus.fu_pkt.decoded_vals.dest_tag, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("stl_order_done", bus.fu_done, 1);
      check("stl_order_tag", bus.fu_pkt.decoded_vals.dest_tag, i);
      check("stl_order_res", bus.fu_pkt.result, (i + 1) * 10);
    end
    tick();
    check("stl_empty", bus.fu_done, 0);

    drive(1'b1, MUL, 32'd2, 32'd3, 6'd10, 4'b0010);
    tick();
    drive(1'b1, MUL, 32'd4, 32'd5, 6'd11, 4'b0100);
    tick();
    drive(1'b1, MUL, 32'd6, 32'd7, 6'd12, 4'b0010);
    tick();
    drive(1'b1, MUL, 32'd8, 32'd9, 6'd13, 4'b0010);
    bus.rem_br_task = SQUASH;
    bus.rem_b_id = 4'b0010;
    tick();
    bus.rem_br_task = NOTHING;
    bus.rem_b_id = '0;
    idle();
    check("sq_a_gone", bus.fu_done, 0);
    tick();
    check("sq_b_done", bus.fu_done, 1);
    check("sq_b_tag", bus.fu_pkt.decoded_vals.dest_tag, 11);
    check("sq_b_res", bus.fu_pkt.result, 20);
    tick();
    check("sq_c_gone", bus.fu_done, 0);
    tick();
    check("sq_issue_gone", bus.fu_done, 0);

    drive(1'b1, MUL, 32'd9, 32'd9, 6'd20, 4'b0110);
    tick();
    idle();
    repeat (N - 1) tick();
    check("clr_done", bus.fu_done, 1);
    bus.stall = 1'b1;
    bus.rem_br_task = CLEAR;
    bus.rem_b_id = 4'b0010;
    tick();
    bus.rem_br_task = NOTHING;
    bus.rem_b_id = '0;
    check("clr_still_done", bus.fu_done, 1);
    check("clr_mask", bus.fu_pkt.decoded_vals.b_mask, 4'b0100);
    check("clr_res", bus.fu_pkt.result, 81);
    tick();
    check("clr_hold_mask", bus.fu_pkt.decoded_vals.b_mask, 4'b0100);
    bus.rem_br_task = SQUASH;
    bus.rem_b_id = 4'b0100;
    tick();
    bus.rem_br_task = NOTHING;
    bus.rem_b_id = '0;
    check("sqf_gone", bus.fu_done, 0);
    check("sqf_ready", bus.ready, 1);
    bus.stall = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MULHU, 32'hFFFF0000, 32'(i + 3), 6'(30 + i), '0);
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_done", bus.fu_done, 0);
    check("mrst_ready", bus.ready, 1);
    check("mrst_pkt", bus.fu_pkt, 0);
    for (int k = 0; k < N + 2; k++) begin
      tick();
      check("mrst_stale", bus.fu_done, 0);
    end

    q.delete();
    for (int c = 0; c < 3000; c++) begin
      bus.stall = ($urandom_range(0, 3) == 0);
      grant_check("rnd");
      if (!(bus.fu_done && bus.stall) && $urandom_range(0, 3) != 0) begin
        rf = MULT_FUNC'($urandom_range(0, 3));
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
        if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
        rt = 6'($urandom);
        drive(1'b1, rf, ra, rb, rt, '0);
        q.push_back('{tag: rt, r: model(rf, ra, rb)});
      end else idle();
      tick();
    end
    idle();
    bus.stall = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      grant_check("drain");
      tick();
    end
    check("drain_empty", q.size(), 0);
    check("drain_idle", bus.fu_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit. Accepts one issued multiply per cycle from the reservation station and produces an `FU_PACKET` with `fu_done` toward the CDB arbiter. Freezes in place while the CDB withholds a grant, and applies branch squash/clear to every in-flight entry. Sits between RS issue and one `cdb` request slot.

## Interface
- `NUM_STAGES`, 4, pipeline depth; power of two, 2..8; each stage consumes `64/NUM_STAGES` multiplier bits.
- `XLEN`, 32, operand width.
- `clock`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `issue_valid`  in  1  RS issues a multiply this cycle
- `issue_pkt`  in  RS_PACKET  decoded_vals (dest tags, b_mask, b_id, valid) plus mult function
- `rs1_value`, `rs2_value`  in  XLEN each  source operands
- `stall`  in  1  this unit's `stall_sig` bit from `cdb`
- `rem_br_task`  in  BR_TASK  NOTHING / CLEAR / SQUASH
- `rem_b_id`  in  BR_MASK  one-hot branch being resolved
- `ready`  out  1  unit can accept `issue_valid` this cycle
- `fu_done`  out  1  output packet valid, requesting CDB
- `fu_pkt`  out  FU_PACKET  decoded_vals + 32-bit result

## Operation
- Functions: MUL (low 32), MULH (s×s high), MULHSU (s×u high), MULHU (u×u high). Operands sign- or zero-extended to 64 bits at issue per function.
- Stage k: accumulates partial products of multiplier bits `[k*W +: W]`, W = 64/NUM_STAGES; carries multiplicand shifted, multiplier, product, packet, valid.
- Last stage register drives `fu_pkt`/`fu_done`; result = product[31:0] for MUL, product[63:32] otherwise.
- Freeze: `frozen = fu_done & stall`. While frozen, all stage registers hold; `ready = ~frozen`. Issue while `~ready` is illegal (assertion).
- Not frozen: pipeline advances every cycle; bubbles advance too (no bubble collapse).
- SQUASH: every stage (including output register and the incoming issue) with `b_mask & rem_b_id` nonzero and `b_id != rem_b_id` has valid cleared, same edge; applies even when frozen. A squashed output drops `fu_done` next cycle.
- CLEAR: `b_mask &= ~rem_b_id` on every stage and incoming issue, same edge, frozen or not.
- Invalid-issue packets (`issue_valid=0`) enter as zero bubbles.

## Timing
- Reset: all stage valids 0, `fu_done=0`, `fu_pkt='0`, `ready=1`, counters 0.
- Latency: issue at edge t → `fu_done` high after edge t+NUM_STAGES-1 (NUM_STAGES cycles issue-to-done). Throughput 1/cycle.
- `fu_done` stays high with stable `fu_pkt` until a cycle with `stall=0` (grant); next edge advances.
- `stall` and branch task same cycle: squash wins; frozen entry invalidated.
- Reset mid-operation: all in-flight ops discarded at that edge.

## Configuration
- `MULT_FU_STATS_EN`: defined → adds 32-bit outputs `stat_done_cnt` (granted completions) and `stat_stall_cnt` (frozen cycles), saturating, reset to 0. Undefined → ports and counters absent; function unchanged.

## Structure
- `MULT_FUNC` enum and `MULT_STAGE_PKT` struct go in `sys_defs.svh`; `FU_PACKET`, `BR_TASK`, `BR_MASK` reused.
- One sub-module `mult_stage` (one partial-product step + branch-mask update), instantiated NUM_STAGES times in a generate loop.

## Test plan
- MUL 7×6, no stall → `fu_done` 4 cycles after issue, result 42.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Back-to-back 4 issues, `stall` held 3 cycles at first done → `ready=0` 3 cycles, packets emerge in order, none lost/duplicated.
- Entries with b_mask 0b0010 in stages 1 and 3, SQUASH b_id 0b0010 → both vanish, 0b0100-masked entry survives.
- CLEAR 0b0010 while output frozen → held `fu_pkt.b_mask` bit cleared, `fu_done` stays high.
- Reset asserted with 3 ops in flight → next cycle `fu_done=0`, `ready=1`, no stale result later.
